// File: rtl/rr_reg_arbiter_pkg.sv
// Shared definitions for the round-robin register arbiter.
//   state_e : FSM state encodings (IDLE/LOAD/ACK; 2'b11 is unused)
//   clog2   : ceiling log2 helper used to size the owner index
package rr_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ACK  = 2'b10
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_reg_arbiter_d_ff_en.sv
// Enabled D register with asynchronous active-high reset.
//   clk  : rising-edge clock
//   rst  : async reset, clears q_o
//   en_i : load enable
//   d_i  : W-bit data in
//   q_o  : W-bit registered data out
module d_ff_en #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit enabled register among N requesters.
// A winner is picked in IDLE, its word is loaded in LOAD, and a one-cycle
// ack pulse is issued in ACK. One transfer at most every three cycles.
//   clk   : rising-edge clock
//   rst   : async active-high reset
//   req   : N request lines, held until the matching ack is seen
//   data  : N flattened W-bit words, requester i at data[i*W +: W]
//   ack   : one-hot one-cycle pulse, word of owner now on Q
//   owner : index of current/last granted requester
//   busy  : high in LOAD and ACK
//   Q     : shared register contents
module rr_reg_arbiter
  import rr_reg_arbiter_pkg::*;
#(
  parameter  int unsigned W    = 5,
  parameter  int unsigned N    = 4,
  localparam int unsigned IDXW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  data,
  output logic [N-1:0]    ack,
  output logic [IDXW-1:0] owner,
  output logic            busy,
  output logic [W-1:0]    Q
);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]      ack_q, ack_d;

  logic              pick_valid;
  logic [IDXW-1:0]   pick_idx;
  logic [IDXW:0]     cand_w;
  logic [IDXW-1:0]   cand;

  logic [W-1:0]      words [N];
  logic              ld_en;
  logic [W-1:0]      ld_d;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      words[i] = data[i*W +: W];
    end
  end

  // Rotate-by-ptr priority encoder: candidates ptr, ptr+1, ... wrapped
  // modulo N with one extra bit so non-power-of-two N never overflows.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_w     = '0;
    cand       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand_w = {1'b0, ptr_q} + (IDXW+1)'(k);
      if (cand_w >= (IDXW+1)'(N)) begin
        cand_w = cand_w - (IDXW+1)'(N);
      end
      cand = cand_w[IDXW-1:0];
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          state_d = LOAD;
        end
      end
      LOAD: state_d = ACK;
      ACK: begin
        state_d = IDLE;
        ptr_d   = (owner_q == IDXW'(N-1)) ? '0 : owner_q + IDXW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_en = (state_q == LOAD);
    ld_d  = words[owner_q];
    ack_d = '0;
    if (state_q == LOAD) begin
      ack_d[owner_q] = 1'b1;
    end
    busy = (state_q == LOAD) || (state_q == ACK);
  end

  d_ff_en #(.W(W)) u_qreg (
    .clk  (clk),
    .rst  (rst),
    .en_i (ld_en),
    .d_i  (ld_d),
    .q_o  (Q)
  );

  assign ack   = ack_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
module tb_rr_reg_arbiter;

  localparam int W    = 5;
  localparam int N    = 4;
  localparam int IDXW = 2;
  localparam time PERIOD = 10;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*W-1:0]  data;
  logic [N-1:0]    ack;
  logic [IDXW-1:0] owner;
  logic            busy;
  logic [W-1:0]    Q;

  typedef struct {
    logic [IDXW-1:0] idx;
    logic [W-1:0]    word;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  rr_reg_arbiter #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .data  (data),
    .ack   (ack),
    .owner (owner),
    .busy  (busy),
    .Q     (Q)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  task automatic set_word(input int i, input logic [W-1:0] v);
    data[i*W +: W] = v;
  endtask

  // Waits (bounded) on negedges for an ack pulse and returns what was seen.
  task automatic wait_ack(input int limit, output logic ok, output logic [N-1:0] a,
                          output logic [W-1:0] qv, output logic [IDXW-1:0] ow,
                          output time t);
    ok = 1'b0; a = '0; qv = '0; ow = '0; t = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ack !== '0) begin
        ok = 1'b1; a = ack; qv = Q; ow = owner; t = $time;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({Q, ack, busy, owner} !== '0) begin
      failures++;
      $display("FAIL reset_state: Q=%b ack=%b busy=%b owner=%0d, required all zero", Q, ack, busy, owner);
    end
    rst = 1'b0;
    set_word(2, 5'b10101);
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || owner !== 2'd2) begin
      failures++;
      $display("FAIL reset_load_entry: busy=%b owner=%0d, required busy=1 owner=2", busy, owner);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (Q !== '0 || ack !== '0 || busy !== 1'b0 || owner !== '0) begin
      failures++;
      $display("FAIL reset_midload: Q=%b ack=%b busy=%b owner=%0d, required all zero", Q, ack, busy, owner);
    end
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ack !== '0) begin
        failures++;
        $display("FAIL reset_idle_after: busy=%b ack=%b, required busy=0 ack=0000", busy, ack);
      end
    end
  endtask

  task automatic test_single;
    exp_t e;
    set_word(1, 5'b11001);
    req = 4'b0010;
    sb.push_back('{idx: 2'd1, word: 5'b11001});
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ack !== '0) begin
      failures++;
      $display("FAIL single_after_e0: busy=%b ack=%b, required busy=1 ack=0000", busy, ack);
    end
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (ack !== (4'b0001 << e.idx) || Q !== e.word || owner !== e.idx) begin
      failures++;
      $display("FAIL single_after_e1: ack=%b Q=%b owner=%0d, required ack=%b Q=%b owner=%0d",
               ack, Q, owner, 4'b0001 << e.idx, e.word, e.idx);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (ack !== '0 || busy !== 1'b0 || Q !== 5'b11001) begin
      failures++;
      $display("FAIL single_after_e2: ack=%b busy=%b Q=%b, required ack=0000 busy=0 Q=11001", ack, busy, Q);
    end
  endtask

  task automatic test_all_requesting;
    logic ok; logic [N-1:0] a; logic [W-1:0] qv; logic [IDXW-1:0] ow;
    time t, tprev;
    exp_t e;
    // restart with ptr at 0
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    set_word(0, 5'b00011); set_word(1, 5'b00101);
    set_word(2, 5'b01010); set_word(3, 5'b10100);
    req = 4'b1111;
    sb.push_back('{idx: 2'd0, word: 5'b00011});
    sb.push_back('{idx: 2'd1, word: 5'b00101});
    sb.push_back('{idx: 2'd2, word: 5'b01010});
    sb.push_back('{idx: 2'd3, word: 5'b10100});
    sb.push_back('{idx: 2'd0, word: 5'b00011});
    tprev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(10, ok, a, qv, ow, t);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL all_timeout: transfer %0d saw no ack, required an ack within 10 cycles", k);
        sb.delete();
        req = '0;
        return;
      end
      e = sb.pop_front();
      checks++;
      if (a !== (4'b0001 << e.idx) || qv !== e.word || ow !== e.idx) begin
        failures++;
        $display("FAIL all_order[%0d]: ack=%b Q=%b owner=%0d, required ack=%b Q=%b owner=%0d",
                 k, a, qv, ow, 4'b0001 << e.idx, e.word, e.idx);
      end
      if (k > 0) begin
        checks++;
        if (t - tprev !== 3*PERIOD) begin
          failures++;
          $display("FAIL all_spacing[%0d]: gap=%0t, required %0t", k, t - tprev, 3*PERIOD);
        end
      end
      tprev = t;
      req[ow] = 1'b0;
      if (k == 2) req[0] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    logic ok; logic [N-1:0] a; logic [W-1:0] qv; logic [IDXW-1:0] ow;
    time t;
    exp_t e;
    set_word(0, 5'b01110); set_word(2, 5'b00111); set_word(3, 5'b11100);
    req = 4'b0100;
    sb.push_back('{idx: 2'd2, word: 5'b00111});
    sb.push_back('{idx: 2'd3, word: 5'b11100});
    sb.push_back('{idx: 2'd0, word: 5'b01110});
    for (int k = 0; k < 3; k++) begin
      wait_ack(10, ok, a, qv, ow, t);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL wrap_timeout: transfer %0d saw no ack, required an ack within 10 cycles", k);
        sb.delete();
        req = '0;
        return;
      end
      e = sb.pop_front();
      checks++;
      if (a !== (4'b0001 << e.idx) || qv !== e.word || ow !== e.idx) begin
        failures++;
        $display("FAIL wrap_order[%0d]: ack=%b Q=%b owner=%0d, required ack=%b Q=%b owner=%0d",
                 k, a, qv, ow, 4'b0001 << e.idx, e.word, e.idx);
      end
      req[ow] = 1'b0;
      if (k == 0) req = 4'b1001;
    end
    @(negedge clk);
  endtask

  task automatic test_stale_data;
    logic ok; logic [N-1:0] a; logic [W-1:0] qv; logic [IDXW-1:0] ow;
    time t;
    exp_t e;
    set_word(0, 5'b00001);
    req = 4'b0001;
    sb.push_back('{idx: 2'd0, word: 5'b00001});
    wait_ack(10, ok, a, qv, ow, t);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stale_timeout: saw no ack, required an ack within 10 cycles");
      sb.delete();
      req = '0;
      return;
    end
    e = sb.pop_front();
    checks++;
    if (a !== (4'b0001 << e.idx) || qv !== e.word) begin
      failures++;
      $display("FAIL stale_load: ack=%b Q=%b, required ack=%b Q=%b", a, qv, 4'b0001 << e.idx, e.word);
    end
    req = '0;
    set_word(0, 5'b11111);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (Q !== 5'b00001 || busy !== 1'b0) begin
        failures++;
        $display("FAIL stale_hold[%0d]: Q=%b busy=%b, required Q=00001 busy=0", i, Q, busy);
      end
    end
  endtask

  task automatic test_simultaneous;
    logic ok; logic [N-1:0] a; logic [W-1:0] qv; logic [IDXW-1:0] ow;
    time t;
    set_word(1, 5'b01011); set_word(2, 5'b10010);
    req = 4'b0010;
    wait_ack(10, ok, a, qv, ow, t);
    checks++;
    if (!ok || a !== 4'b0010 || qv !== 5'b01011) begin
      failures++;
      $display("FAIL simul_first: ok=%b ack=%b Q=%b, required ok=1 ack=0010 Q=01011", ok, a, qv);
    end
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ack !== '0 || owner !== 2'd1) begin
      failures++;
      $display("FAIL simul_idle: busy=%b ack=%b owner=%0d, required busy=0 ack=0000 owner=1", busy, ack, owner);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ack !== '0 || owner !== 2'd2) begin
      failures++;
      $display("FAIL simul_load: busy=%b ack=%b owner=%0d, required busy=1 ack=0000 owner=2", busy, ack, owner);
    end
    @(negedge clk);
    checks++;
    if (ack !== 4'b0100 || Q !== 5'b10010) begin
      failures++;
      $display("FAIL simul_grant2: ack=%b Q=%b, required ack=0100 Q=10010", ack, Q);
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_requesting();
    test_wrap();
    test_stale_data();
    test_simultaneous();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
